// File: rtl/pll_reset_sequencer.sv
// PLL lock supervisor: synchronizes locked_in, waits for a stable lock before
// releasing the system reset, and re-asserts it for a minimum hold after lock loss.
module pll_reset_sequencer #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       locked_in,
  output logic       reset_out,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] lost_count,
  output logic       lock_timeout
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2,
    HOLD      = 2'd3
  } state_t;

  localparam int unsigned MAX_SH     = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int unsigned MAX_CYCLES = (MAX_SH > TIMEOUT_CYCLES) ? MAX_SH : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES);

  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_sync;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   timeout_d;

  assign locked_sync = sync_q[SYNC_STAGES-1];
  assign state       = state_q;
  assign ready       = ~reset_out;

  // Loss of lock is tested before any counter boundary so it always wins.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    timeout_d = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        if (locked_sync) begin
          state_d = STABILIZE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
        end
      end
      STABILIZE: begin
        if (!locked_sync) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!locked_sync) state_d = HOLD;
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q       <= '0;
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      reset_out    <= 1'b1;
      lost_count   <= '0;
      lock_timeout <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], locked_in};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      reset_out    <= (state_d != RUN);
      lock_timeout <= timeout_d;
      if (state_q == RUN && !locked_sync && lost_count != 8'hFF)
        lost_count <= lost_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: a reference model predicts every
// cycle's outputs into a queue, a monitor pops and compares on the falling edge.
module tb_pll_reset_sequencer;

  localparam int unsigned SYNC   = 2;
  localparam int unsigned STABLE = 16;
  localparam int unsigned HOLD   = 8;
  localparam int unsigned TMO    = 64;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       locked_in = 1'b0;
  logic       reset_out, ready, lock_timeout;
  logic [1:0] state;
  logic [7:0] lost_count;

  pll_reset_sequencer #(
    .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset(reset), .locked_in(locked_in), .reset_out(reset_out),
    .ready(ready), .state(state), .lost_count(lost_count), .lock_timeout(lock_timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    int       eidx;
    bit       ro;
    bit       rdy;
    bit [1:0] st;
    bit [7:0] lc;
    bit       to;
  } exp_t;

  exp_t     exp_q[$];
  int       n_checks = 0;
  int       n_pass = 0;
  bit       obs_ro[$];
  bit [1:0] obs_st[$];
  bit       obs_to[$];
  int       prev_lost;
  bit       wrap_seen = 1'b0;

  // Reference model: phase numbers follow the published state encoding,
  // time in a phase is measured from the edge that entered it.
  int m_phase, m_since, m_edge, m_lost;
  bit m_to;
  bit m_hist[$];

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, expv);
  endtask

  task automatic model_init();
    m_phase = 0; m_since = 0; m_edge = 0; m_lost = 0; m_to = 0;
    m_hist.delete();
  endtask

  task automatic model_step(input bit v);
    bit ls;
    int elapsed;
    exp_t e;
    m_edge++;
    ls = (m_hist.size() >= SYNC) ? m_hist[0] : 1'b0;
    m_hist.push_back(v);
    if (m_hist.size() > SYNC) void'(m_hist.pop_front());
    elapsed = m_edge - m_since - 1;
    m_to = 1'b0;
    case (m_phase)
      0: if (ls) begin m_phase = 1; m_since = m_edge; end
         else m_to = ((elapsed % TMO) == TMO - 1);
      1: if (!ls) begin m_phase = 0; m_since = m_edge; end
         else if (elapsed == STABLE - 1) begin m_phase = 2; m_since = m_edge; end
      2: if (!ls) begin
           m_phase = 3; m_since = m_edge;
           if (m_lost < 255) m_lost++;
         end
      default: if (elapsed == HOLD - 1) begin m_phase = 0; m_since = m_edge; end
    endcase
    e.eidx = m_edge;
    e.ro   = (m_phase != 2);
    e.rdy  = !e.ro;
    e.st   = 2'(m_phase);
    e.lc   = 8'(m_lost);
    e.to   = m_to;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit v);
    locked_in = v;
    @(posedge clock);
    #1;
    model_step(v);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin #1; t++; end
    chk("drain", exp_q.size(), 0);
    #1;
  endtask

  task automatic do_reset();
    drain();
    @(negedge clock);
    reset = 1'b1;
    locked_in = 1'b0;
    #1;
    chk("rst reset_out", reset_out, 1);
    chk("rst ready", ready, 0);
    chk("rst state", state, 0);
    chk("rst lost_count", lost_count, 0);
    chk("rst lock_timeout", lock_timeout, 0);
    repeat (2) @(negedge clock);
    model_init();
    reset = 1'b0;
  endtask

  function automatic int first_ro(input bit val, input int from_idx);
    for (int i = from_idx; i < obs_ro.size(); i++)
      if (obs_ro[i] == val) return i + 1;
    return -1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d, cnt, len;
    int to_edges[$];
    bit v;

    fork
      forever begin
        @(negedge clock);
        if (!reset && exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.eidx == 1) begin
            obs_ro.delete(); obs_st.delete(); obs_to.delete(); prev_lost = 0;
          end
          chk($sformatf("e%0d reset_out", e.eidx), reset_out, e.ro);
          chk($sformatf("e%0d ready", e.eidx), ready, e.rdy);
          chk($sformatf("e%0d state", e.eidx), state, e.st);
          chk($sformatf("e%0d lost_count", e.eidx), lost_count, e.lc);
          chk($sformatf("e%0d lock_timeout", e.eidx), lock_timeout, e.to);
          obs_ro.push_back(reset_out);
          obs_st.push_back(state);
          obs_to.push_back(lock_timeout);
          if (int'(lost_count) < prev_lost) wrap_seen = 1'b1;
          prev_lost = int'(lost_count);
        end
      end
    join_none

    // Lock present before the first edge: STABILIZE after edge 3, release after edge 19.
    do_reset();
    repeat (25) step(1'b1);
    drain();
    chk("t29 state@3", obs_st[2], 1);
    chk("t29 release edge", first_ro(1'b0, 0), 19);
    chk("t29 lost_count", lost_count, 0);

    // No lock: timeout pulses at edges 64, 128, 192.
    do_reset();
    repeat (200) step(1'b0);
    drain();
    to_edges.delete();
    for (int i = 0; i < obs_to.size(); i++) if (obs_to[i]) to_edges.push_back(i + 1);
    chk("t30 pulse count", to_edges.size(), 3);
    for (int i = 0; i < to_edges.size(); i++)
      chk($sformatf("t30 pulse%0d edge", i), to_edges[i], 64 * (i + 1));
    chk("t30 never released", first_ro(1'b0, 0), -1);

    // One-cycle dropout seen by the FSM at STABILIZE counter 10.
    do_reset();
    repeat (11) step(1'b1);
    step(1'b0);
    repeat (25) step(1'b1);
    drain();
    chk("t31 state@13", obs_st[12], 1);
    chk("t31 state@14", obs_st[13], 0);
    chk("t31 release edge", first_ro(1'b0, 0), 31);

    // Permanent loss while in RUN.
    d = m_edge + 1;
    repeat (15) step(1'b0);
    drain();
    chk("t32 reassert edge", first_ro(1'b1, d - 1), d + 2);
    cnt = 0;
    foreach (obs_st[i]) if (obs_st[i] == 2'd3) cnt++;
    chk("t32 hold cycles", cnt, HOLD);
    chk("t32 state after hold", obs_st[d + 9], 0);
    chk("t32 lost_count", lost_count, 1);

    // Random run lengths, including short glitches.
    v = 1'b1;
    for (int s = 0; s < 60; s++) begin
      len = $urandom_range(1, 25);
      repeat (len) step(v);
      v = ~v;
    end

    // 300 full lock/loss cycles: lost_count must saturate.
    for (int k = 0; k < 300; k++) begin
      repeat ($urandom_range(20, 30)) step(1'b1);
      repeat ($urandom_range(12, 20)) step(1'b0);
    end
    drain();
    chk("t33 lost_count sat", lost_count, 255);
    chk("t33 no wrap", wrap_seen, 0);

    // Asynchronous reset mid-cycle while in RUN.
    repeat (25) step(1'b1);
    drain();
    chk("t34 in RUN", reset_out, 0);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("t34 reset_out", reset_out, 1);
    chk("t34 ready", ready, 0);
    chk("t34 state", state, 0);
    chk("t34 lost_count", lost_count, 0);
    chk("t34 lock_timeout", lock_timeout, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on locked_in (legal range 2..4).
REQ-002 The block SHALL have parameter STABLE_CYCLES, default 1024, consecutive synchronized-lock cycles required before releasing reset (legal range 1..65535).
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 16, minimum reset-hold cycles after a lock loss (legal range 1..65535).
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 65536, cycles spent in WAIT_LOCK without lock before a timeout pulse (legal range 2..2^20).
REQ-005 The block SHALL have port clock, input, 1 bit: the PLL output clock; all state is clocked on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high block reset.
REQ-007 The block SHALL have port locked_in, input, 1 bit: PLL lock indicator, asynchronous to clock.
REQ-008 The block SHALL have port reset_out, output, 1 bit: active-high system reset, asserted asynchronously and released synchronously.
REQ-009 The block SHALL have port ready, output, 1 bit: the exact complement of reset_out.
REQ-010 The block SHALL have port state, output, 2 bits: current FSM state encoding.
REQ-011 The block SHALL have port lost_count, output, 8 bits: number of lock losses seen in RUN.
REQ-012 The block SHALL have port lock_timeout, output, 1 bit: single-cycle pulse on a lock-acquisition timeout.

Function
REQ-013 locked_in SHALL pass through a SYNC_STAGES-deep flop chain reset to 0; locked_sync is the last stage, and no other logic samples locked_in.
REQ-014 FSM encoding SHALL be WAIT_LOCK=0, STABILIZE=1, RUN=2, HOLD=3.
REQ-015 There SHALL be a single shared cycle counter, sized to the largest of STABLE_CYCLES, HOLD_CYCLES and TIMEOUT_CYCLES, and cleared to 0 on every state transition.
REQ-016 WAIT_LOCK: if locked_sync=1, the FSM SHALL move to STABILIZE at the next edge; otherwise the counter increments.
REQ-017 WAIT_LOCK: when counter = TIMEOUT_CYCLES-1 and locked_sync=0, lock_timeout SHALL be 1 for exactly the next cycle, the counter wraps to 0, and the state stays WAIT_LOCK.
REQ-018 STABILIZE: if locked_sync=0, the FSM SHALL return to WAIT_LOCK and clear the counter; no glitch filtering applies.
REQ-019 STABILIZE: if locked_sync=1 and counter = STABLE_CYCLES-1, the FSM SHALL move to RUN; otherwise the counter increments.
REQ-020 RUN: if locked_sync=0, the FSM SHALL move to HOLD at the next edge, and lost_count increments on that same edge, saturating at 255.
REQ-021 HOLD: the FSM SHALL stay for exactly HOLD_CYCLES cycles regardless of locked_sync, then move to WAIT_LOCK.
REQ-022 reset_out SHALL be a register loaded with (next_state != RUN), so it falls on the same edge at which state becomes RUN and rises on the same edge at which state leaves RUN.
REQ-023 Release latency SHALL be exactly SYNC_STAGES+1+STABLE_CYCLES edges, counted from the first edge at which locked_in is sampled high and held steady, to reset_out=0.
REQ-024 If a loss of lock and a transition boundary coincide, the loss of lock SHALL take priority; e.g. STABILIZE with counter at STABLE_CYCLES-1 and locked_sync=0 goes to WAIT_LOCK.
REQ-025 lost_count SHALL only be cleared by reset; lock_timeout SHALL never be asserted outside WAIT_LOCK.

Reset
REQ-026 While reset=1, all flops SHALL be asynchronously forced to: sync chain=0, state=WAIT_LOCK, counter=0, reset_out=1, ready=0, lost_count=0, lock_timeout=0.
REQ-027 On reset deassertion, operation SHALL begin in WAIT_LOCK at the next rising edge.
REQ-028 Reset asserted mid-operation, including in RUN, SHALL force reset_out=1 immediately without waiting for a clock edge.

Verification (SYNC_STAGES=2, STABLE_CYCLES=16, HOLD_CYCLES=8, TIMEOUT_CYCLES=64)
REQ-029 Test: release reset with locked_in=1 already set before edge 1 -> state=1 after edge 3, reset_out=0 and ready=1 after edge 19, lost_count=0.
REQ-030 Test: hold locked_in=0 for 200 cycles -> lock_timeout pulses exactly 3 times, 64 cycles apart, each 1 cycle wide; reset_out stays 1.
REQ-031 Test: drop locked_in for 1 cycle during STABILIZE at counter=10 -> return to WAIT_LOCK; release occurs a full 19 edges after locked_in is high again.
REQ-032 Test: in RUN, drop locked_in permanently -> reset_out=1 at edge 3 after the drop, lost_count=1, state=3 for 8 cycles, then state=0.
REQ-033 Test: repeat the lock-loss cycle 300 times -> lost_count saturates at 255 and never wraps.
REQ-034 Test: assert reset asynchronously mid-cycle while in RUN -> reset_out=1 before the next edge, and all outputs match their REQ-026 values.
